// File: rtl/mw_stage_skid_pkg.sv
// mw_stage_skid_pkg: shared definitions for the MEM->WB skid stage.
//   mw_payload_t  - layout of one M->W entry at the default widths
//   MW_CTRL_MASK  - selects the control bits cleared on a bubble
//   mw_gate_ctrl  - applies the bubble gating to a control triple
package mw_stage_skid_pkg;

  localparam int MW_DATA_W = 32;
  localparam int MW_RA_W   = 4;
  localparam int MW_CTRL_W = 3;

  // Field order matches the flattened vector used by the stage:
  // controls in the top bits, destination register in the low bits.
  typedef struct packed {
    logic                 PCSrc;
    logic                 RegWrite;
    logic                 MemtoReg;
    logic [MW_DATA_W-1:0] ReadData;
    logic [MW_DATA_W-1:0] ALUOut;
    logic [MW_RA_W-1:0]   WA3;
  } mw_payload_t;

  // Control bits (PCSrc, RegWrite, MemtoReg) forced low when no valid entry.
  localparam logic [MW_CTRL_W-1:0] MW_CTRL_MASK = 3'b111;

  // Returns the controls unchanged when the entry is valid, masked otherwise.
  function automatic logic [MW_CTRL_W-1:0] mw_gate_ctrl(
    input logic [MW_CTRL_W-1:0] ctrl,
    input logic                 keep
  );
    logic [MW_CTRL_W-1:0] g;
    if (keep) begin
      g = ctrl;
    end else begin
      g = ctrl & ~MW_CTRL_MASK;
    end
    return g;
  endfunction

endpackage

// File: rtl/mw_stage_skid_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset.
//   CLK     - clock
//   RESET   - synchronous clear
//   inc     - count enable for this edge
//   o_count - current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Count up on inc until the maximum value, then hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mw_stage_skid.sv
// mw_stage_skid: MEM->WB pipeline register with valid/ready handshake,
// a two-entry (main + skid) buffer, synchronous flush and two saturating
// performance counters.
//   CLK, RESET      - clock, synchronous active-high reset
//   FlushM          - kill held entries and the same-cycle input
//   ValidM / ReadyM - upstream handshake (ReadyM is a flop output)
//   PCSrcM, RegWriteM, MemtoRegM, ReadData, ALUOutM, WA3M - M-stage payload
//   ValidW / ReadyW - downstream handshake
//   PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W - W-stage payload
//   BubbleCnt       - edges seen with ValidW=0
//   StallCnt        - edges seen with ValidW=1 and ReadyW=0
module mw_stage_skid
  import mw_stage_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FlushM,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [RA_W-1:0]   WA3M,
  output logic              ValidW,
  input  logic              ReadyW,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [RA_W-1:0]   WA3W,
  output logic [CNT_W-1:0]  BubbleCnt,
  output logic [CNT_W-1:0]  StallCnt
);

  // Flattened entry, same field order as mw_payload_t.
  localparam int PAY_W = MW_CTRL_W + 2 * DATA_W + RA_W;
  localparam int CTL_H = PAY_W - 1;

  logic [PAY_W-1:0] w_in;
  logic             w_accept;
  logic             w_can_load;

  logic [PAY_W-1:0] r_main;
  logic             r_valid_w;
  logic [PAY_W-1:0] r_skid;
  logic             r_skid_valid;
  logic             r_ready_m;

  assign w_in       = {PCSrcM, RegWriteM, MemtoRegM, ReadData, ALUOutM, WA3M};
  assign w_accept   = ValidM & r_ready_m;
  // Main may be overwritten when it is empty or being consumed this edge.
  assign w_can_load = ~r_valid_w | ReadyW;

  // Main/skid buffer state; reset beats flush, flush beats normal flow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_main       <= '0;
      r_valid_w    <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_ready_m    <= 1'b1;
    end else if (FlushM) begin
      // Data fields hold; only the controls are cleared.
      r_main[CTL_H -: MW_CTRL_W] <= mw_gate_ctrl(r_main[CTL_H -: MW_CTRL_W], 1'b0);
      r_valid_w    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready_m    <= 1'b1;
    end else if (w_can_load) begin
      if (r_skid_valid) begin
        // Older skid entry always drains first to keep FIFO order.
        r_main    <= r_skid;
        r_valid_w <= 1'b1;
      end else if (w_accept) begin
        r_main    <= w_in;
        r_valid_w <= 1'b1;
      end else begin
        r_main[CTL_H -: MW_CTRL_W] <= mw_gate_ctrl(r_main[CTL_H -: MW_CTRL_W], 1'b0);
        r_valid_w <= 1'b0;
      end
      r_skid_valid <= 1'b0;
      r_ready_m    <= 1'b1;
    end else if (w_accept) begin
      // Downstream stalled with main full: park the input in the skid.
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
      r_ready_m    <= 1'b0;
    end else begin
      r_ready_m <= ~r_skid_valid;
    end
  end

  assign ReadyM    = r_ready_m;
  assign ValidW    = r_valid_w;
  assign PCSrcW    = r_main[CTL_H];
  assign RegWriteW = r_main[CTL_H-1];
  assign MemtoRegW = r_main[CTL_H-2];
  assign ReadDataW = r_main[2*DATA_W+RA_W-1 -: DATA_W];
  assign ALUOutW   = r_main[DATA_W+RA_W-1 -: DATA_W];
  assign WA3W      = r_main[RA_W-1:0];

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .inc    (~r_valid_w),
    .o_count(BubbleCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .inc    (r_valid_w & ~ReadyW),
    .o_count(StallCnt)
  );

endmodule

// File: tb/tb_mw_stage_skid.sv
// Directed bench for mw_stage_skid, counters built 4 bits wide so the
// saturation point is reachable quickly.
module tb_mw_stage_skid;

  logic        CLK = 1'b0;
  logic        RESET, FlushM, ValidM, ReadyW;
  logic        PCSrcM, RegWriteM, MemtoRegM;
  logic [31:0] ReadData, ALUOutM;
  logic [3:0]  WA3M;
  logic        ReadyM, ValidW, PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WA3W;
  logic [3:0]  BubbleCnt, StallCnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mw_stage_skid #(.DATA_W(32), .RA_W(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ReadData(ReadData), .ALUOutM(ALUOutM), .WA3M(WA3M),
    .ValidW(ValidW), .ReadyW(ReadyW),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
    .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic pc, input logic rw, input logic mr,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [3:0] wa);
    ValidM = v; PCSrcM = pc; RegWriteM = rw; MemtoRegM = mr;
    ReadData = rd; ALUOutM = alu; WA3M = wa;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    RESET = 1'b1; FlushM = 1'b0; ReadyW = 1'b0; idle_in();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (ValidW !== 1'b0) begin n_err++; $display("FAIL reset_validw: got %0b want 0", ValidW); end
    n_cmp++; if (ReadyM !== 1'b1) begin n_err++; $display("FAIL reset_readym: got %0b want 1", ReadyM); end
    n_cmp++; if ({PCSrcW, RegWriteW, MemtoRegW} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %0b want 000", {PCSrcW, RegWriteW, MemtoRegW}); end
    n_cmp++; if ({ReadDataW, ALUOutW, WA3W} !== 68'h0) begin n_err++; $display("FAIL reset_data: got %0h want 0", {ReadDataW, ALUOutW, WA3W}); end
    n_cmp++; if (BubbleCnt !== 4'd5) begin n_err++; $display("FAIL reset_bubble: got %0d want 5", BubbleCnt); end
    n_cmp++; if (StallCnt !== 4'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", StallCnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] alu_v [3];
    logic [3:0]  wa_v  [3];
    alu_v[0] = 32'h11; alu_v[1] = 32'h22; alu_v[2] = 32'h33;
    wa_v[0]  = 4'd3;   wa_v[1]  = 4'd4;   wa_v[2]  = 4'd5;
    do_reset();
    ReadyW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(i), alu_v[i], wa_v[i]);
      tick();
      n_cmp++; if (ValidW !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, ValidW); end
      n_cmp++; if (ALUOutW !== alu_v[i]) begin n_err++; $display("FAIL stream_alu[%0d]: got %0h want %0h", i, ALUOutW, alu_v[i]); end
      n_cmp++; if (WA3W !== wa_v[i]) begin n_err++; $display("FAIL stream_wa3[%0d]: got %0d want %0d", i, WA3W, wa_v[i]); end
      n_cmp++; if (RegWriteW !== 1'b1) begin n_err++; $display("FAIL stream_rw[%0d]: got %0b want 1", i, RegWriteW); end
    end
    idle_in();
    tick();
    n_cmp++; if (ValidW !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %0b want 0", ValidW); end
    n_cmp++; if (RegWriteW !== 1'b0) begin n_err++; $display("FAIL stream_bubble_rw: got %0b want 0", RegWriteW); end
    n_cmp++; if (ALUOutW !== 32'h33) begin n_err++; $display("FAIL stream_bubble_hold: got %0h want 33", ALUOutW); end
  endtask

  task automatic test_stall();
    do_reset();
    ReadyW = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000A, 32'hA0, 4'd1);  // A
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000B, 32'hB0, 4'd2);  // B -> skid
    tick();
    n_cmp++; if (ReadyM !== 1'b0) begin n_err++; $display("FAIL stall_readym: got %0b want 0", ReadyM); end
    n_cmp++; if (ALUOutW !== 32'hA0) begin n_err++; $display("FAIL stall_hold_a: got %0h want a0", ALUOutW); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000C, 32'hCC, 4'd7);  // must be refused
    tick();
    n_cmp++; if (StallCnt !== 4'd2) begin n_err++; $display("FAIL stall_cnt2: got %0d want 2", StallCnt); end
    n_cmp++; if (ALUOutW !== 32'hA0) begin n_err++; $display("FAIL stall_hold_a2: got %0h want a0", ALUOutW); end
    idle_in(); ReadyW = 1'b1;
    tick();
    n_cmp++; if ({ValidW, ALUOutW, WA3W} !== {1'b1, 32'hB0, 4'd2}) begin n_err++; $display("FAIL stall_show_b: got %0h want 1b02", {ValidW, ALUOutW, WA3W}); end
    n_cmp++; if (ReadDataW !== 32'h1000B) begin n_err++; $display("FAIL stall_rd_b: got %0h want 1000b", ReadDataW); end
    n_cmp++; if (ReadyM !== 1'b1) begin n_err++; $display("FAIL stall_readym_back: got %0b want 1", ReadyM); end
    tick();
    n_cmp++; if ({ValidW, ALUOutW} !== {1'b0, 32'hB0}) begin n_err++; $display("FAIL stall_after_b: got %0h want 0b0", {ValidW, ALUOutW}); end
    n_cmp++; if (StallCnt !== 4'd2) begin n_err++; $display("FAIL stall_cnt_final: got %0d want 2", StallCnt); end
    n_cmp++; if (BubbleCnt !== 4'd1) begin n_err++; $display("FAIL stall_bubble: got %0d want 1", BubbleCnt); end
  endtask

  task automatic test_flush();
    do_reset();
    ReadyW = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h5A5A, 32'hA1, 4'd9);   // A, all controls set
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hB1, 4'd10);    // B -> skid
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hC1, 4'd11);    // C with flush
    FlushM = 1'b1;
    tick();
    FlushM = 1'b0;
    n_cmp++; if (ValidW !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", ValidW); end
    n_cmp++; if ({PCSrcW, RegWriteW, MemtoRegW} !== 3'b000) begin n_err++; $display("FAIL flush_ctrl: got %0b want 000", {PCSrcW, RegWriteW, MemtoRegW}); end
    n_cmp++; if (ReadyM !== 1'b1) begin n_err++; $display("FAIL flush_readym: got %0b want 1", ReadyM); end
    n_cmp++; if ({ALUOutW, ReadDataW} !== {32'hA1, 32'h5A5A}) begin n_err++; $display("FAIL flush_data_hold: got %0h want a100005a5a", {ALUOutW, ReadDataW}); end
    idle_in(); ReadyW = 1'b1;
    tick(); tick();
    n_cmp++; if ({ValidW, ALUOutW} !== {1'b0, 32'hA1}) begin n_err++; $display("FAIL flush_no_b_c: got %0h want 0a1", {ValidW, ALUOutW}); end
    // Flush with an accept that would otherwise have landed in main.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hE0, 4'd4);
    tick();
    n_cmp++; if ({ValidW, ALUOutW} !== {1'b1, 32'hE0}) begin n_err++; $display("FAIL flush_pre_e: got %0h want 1e0", {ValidW, ALUOutW}); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hF0, 4'd5);
    FlushM = 1'b1;
    tick();
    FlushM = 1'b0; idle_in();
    n_cmp++; if ({ValidW, ALUOutW, RegWriteW} !== {1'b0, 32'hE0, 1'b0}) begin n_err++; $display("FAIL flush_drop_f: got %0h want e0 valid0 rw0", {ValidW, ALUOutW, RegWriteW}); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (BubbleCnt !== 4'd15) begin n_err++; $display("FAIL sat_bubble: got %0d want 15", BubbleCnt); end
    n_cmp++; if (StallCnt !== 4'd0) begin n_err++; $display("FAIL sat_stall: got %0d want 0", StallCnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ReadyW = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h71, 4'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h72, 4'd2);
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_cmp++; if ({ValidW, ReadyM} !== 2'b01) begin n_err++; $display("FAIL rst_mid_hs: got %0b want 01", {ValidW, ReadyM}); end
    n_cmp++; if ({BubbleCnt, StallCnt} !== 8'h00) begin n_err++; $display("FAIL rst_mid_cnt: got %0h want 00", {BubbleCnt, StallCnt}); end
    n_cmp++; if (ALUOutW !== 32'h0) begin n_err++; $display("FAIL rst_mid_alu: got %0h want 0", ALUOutW); end
    ReadyW = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hAB, 4'd6);
    tick();
    idle_in();
    n_cmp++; if ({ValidW, ALUOutW, WA3W} !== {1'b1, 32'hAB, 4'd6}) begin n_err++; $display("FAIL rst_mid_fresh: got %0h want 1ab6", {ValidW, ALUOutW, WA3W}); end
    n_cmp++; if (BubbleCnt !== 4'd1) begin n_err++; $display("FAIL rst_mid_bubble: got %0d want 1", BubbleCnt); end
  endtask

  initial begin
    RESET = 1'b1; FlushM = 1'b0; ReadyW = 1'b0; idle_in();
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
